// File: rtl/rf_wb_arbiter.sv
// Purpose : shares the register-file write port between an ALU path (A) and a
//           long-latency unit (B), and tracks registers reserved by B issues.
// Latency : 1 cycle from grant (o_a_ready/o_b_ready) to o_rd_* on the port.
// Backpr. : A is held off while its rd is reserved; A/B conflicts are resolved
//           round-robin; issue is refused while its rd is already reserved.
//
// Ports
//   i_clk, i_rst                    clock, async active-high reset
//   i_a_valid/o_a_ready/i_a_rd/i_a_data   requester A write
//   i_b_valid/o_b_ready/i_b_rd/i_b_data   requester B write (releases rd)
//   i_issue_valid/o_issue_ready/i_issue_rd  B-unit reservation of rd
//   i_dec_rs1/i_dec_rs2/i_dec_rd, o_hazard  decode-stage stall query
//   o_rd_wren/o_rd_addr/o_rd_data           registered regfile write port
//   o_busy                                  reservation bitmap, bit0 always 0
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_a_valid,
    output logic                  o_a_ready,
    input  logic [AW-1:0]         i_a_rd,
    input  logic [XLEN-1:0]       i_a_data,
    input  logic                  i_b_valid,
    output logic                  o_b_ready,
    input  logic [AW-1:0]         i_b_rd,
    input  logic [XLEN-1:0]       i_b_data,
    input  logic                  i_issue_valid,
    output logic                  o_issue_ready,
    input  logic [AW-1:0]         i_issue_rd,
    input  logic [AW-1:0]         i_dec_rs1,
    input  logic [AW-1:0]         i_dec_rs2,
    input  logic [AW-1:0]         i_dec_rd,
    output logic                  o_hazard,
    output logic                  o_rd_wren,
    output logic [AW-1:0]         o_rd_addr,
    output logic [XLEN-1:0]       o_rd_data,
    output logic [(2**AW)-1:0]    o_busy
);

    localparam int NREG = 2 ** AW;

    // Last requester granted: 0 = A, 1 = B.
    localparam logic LG_A = 1'b0;
    localparam logic LG_B = 1'b1;

    logic [NREG-1:0] r_busy;
    logic            r_last_grant;
    logic            r_wren;
    logic [AW-1:0]   r_addr;
    logic [XLEN-1:0] r_data;

    logic            w_elig_a;
    logic            w_elig_b;
    logic            w_grant_a;
    logic            w_grant_b;
    logic            w_issue_fire;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_haz_rs1;
    logic            w_haz_rs2;
    logic            w_haz_rd;

    // A must not overwrite a register that B still owes a result to,
    // otherwise B's later writeback would clobber A's newer value.
    assign w_elig_a = i_a_valid & ~r_busy[i_a_rd];
    assign w_elig_b = i_b_valid;

    // On conflict, favour whoever did not win last time.
    assign w_grant_a = w_elig_a & (~w_elig_b | (r_last_grant == LG_B));
    assign w_grant_b = w_elig_b & (~w_elig_a | (r_last_grant == LG_A));

    assign o_a_ready = w_grant_a;
    assign o_b_ready = w_grant_b;

    assign o_issue_ready = ~r_busy[i_issue_rd];
    assign w_issue_fire  = i_issue_valid & o_issue_ready;

    // Release first, then reserve, so a same-cycle reserve of the register
    // being released leaves it reserved. x0 never holds state.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_grant_b) begin
            w_busy_nxt[i_b_rd] = 1'b0;
        end
        if (w_issue_fire && (i_issue_rd != '0)) begin
            w_busy_nxt[i_issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // A register is unsafe to read or write if reserved, or if its write is
    // sitting on the port this cycle and not yet in the regfile.
    assign w_haz_rs1 = (i_dec_rs1 != '0) &
                       (r_busy[i_dec_rs1] | (r_wren & (r_addr == i_dec_rs1)));
    assign w_haz_rs2 = (i_dec_rs2 != '0) &
                       (r_busy[i_dec_rs2] | (r_wren & (r_addr == i_dec_rs2)));
    assign w_haz_rd  = (i_dec_rd  != '0) &
                       (r_busy[i_dec_rd]  | (r_wren & (r_addr == i_dec_rd)));
    assign o_hazard  = w_haz_rs1 | w_haz_rs2 | w_haz_rd;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy       <= '0;
            r_last_grant <= LG_B;
            r_wren       <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_grant_a) begin
                r_last_grant <= LG_A;
                r_wren       <= (i_a_rd != '0);
                r_addr       <= i_a_rd;
                r_data       <= i_a_data;
            end else if (w_grant_b) begin
                r_last_grant <= LG_B;
                r_wren       <= (i_b_rd != '0);
                r_addr       <= i_b_rd;
                r_data       <= i_b_data;
            end else begin
                r_wren <= 1'b0;
            end
        end
    end

    assign o_rd_wren = r_wren;
    assign o_rd_addr = r_addr;
    assign o_rd_data = r_data;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_a_valid = 1'b0;
    logic            o_a_ready;
    logic [AW-1:0]   i_a_rd = '0;
    logic [XLEN-1:0] i_a_data = '0;
    logic            i_b_valid = 1'b0;
    logic            o_b_ready;
    logic [AW-1:0]   i_b_rd = '0;
    logic [XLEN-1:0] i_b_data = '0;
    logic            i_issue_valid = 1'b0;
    logic            o_issue_ready;
    logic [AW-1:0]   i_issue_rd = '0;
    logic [AW-1:0]   i_dec_rs1 = '0;
    logic [AW-1:0]   i_dec_rs2 = '0;
    logic [AW-1:0]   i_dec_rd = '0;
    logic            o_hazard;
    logic            o_rd_wren;
    logic [AW-1:0]   o_rd_addr;
    logic [XLEN-1:0] o_rd_data;
    logic [31:0]     o_busy;

    int errors = 0;
    int checks = 0;

    // Expected regfile writes, {addr, data}, in grant order.
    logic [AW+XLEN-1:0] sb_q[$];

    rf_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_rd(i_a_rd), .i_a_data(i_a_data),
        .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_rd(i_b_rd), .i_b_data(i_b_data),
        .i_issue_valid(i_issue_valid), .o_issue_ready(o_issue_ready), .i_issue_rd(i_issue_rd),
        .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2), .i_dec_rd(i_dec_rd), .o_hazard(o_hazard),
        .o_rd_wren(o_rd_wren), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Monitor: every enabled write on the port must match the next expected one.
    always @(negedge i_clk) begin
        if (!i_rst && o_rd_wren) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got addr=%0d data=%h, expected no write",
                         o_rd_addr, o_rd_data);
            end else begin
                logic [AW+XLEN-1:0] e;
                e = sb_q.pop_front();
                if ({o_rd_addr, o_rd_data} !== e) begin
                    errors++;
                    $display("FAIL wb_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             o_rd_addr, o_rd_data, e[AW+XLEN-1:XLEN], e[XLEN-1:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        if (rd != '0) sb_q.push_back({rd, d});
    endtask

    // Inputs change at posedge+1; combinational checks happen at posedge+2.
    task automatic step();
        @(posedge i_clk);
        #1;
        i_a_valid = 1'b0;
        i_b_valid = 1'b0;
        i_issue_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_wren", o_rd_wren, 0);
        chk("rst_addr", o_rd_addr, 0);
        chk("rst_data", o_rd_data, 0);
        chk("rst_busy", o_busy, 0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // 1: lone A write
        i_a_valid = 1; i_a_rd = 5; i_a_data = 32'hDEADBEEF;
        #1;
        chk("t1_a_rdy", o_a_ready, 1);
        exp_wr(5, 32'hDEADBEEF);
        step();
        chk("t1_wren", o_rd_wren, 1);
        chk("t1_addr", o_rd_addr, 5);
        step();

        // Re-reset so A wins the first conflict again
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;

        // 2: A and B contend for four cycles -> A,B,A,B
        for (int k = 0; k < 4; k++) begin
            i_a_valid = 1; i_a_rd = 1; i_a_data = 32'h1111_1111;
            i_b_valid = 1; i_b_rd = 2; i_b_data = 32'h2222_2222;
            #1;
            chk($sformatf("t2_a_rdy%0d", k), o_a_ready, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("t2_b_rdy%0d", k), o_b_ready, (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 0) exp_wr(1, 32'h1111_1111);
            else            exp_wr(2, 32'h2222_2222);
            step();
        end
        step();

        // 3: reservation blocks A, B release unblocks it
        i_issue_valid = 1; i_issue_rd = 7;
        #1;
        chk("t3_iss_rdy", o_issue_ready, 1);
        step();
        chk("t3_busy_set", o_busy, 32'h0000_0080);
        i_dec_rs2 = 7;
        i_a_valid = 1; i_a_rd = 7; i_a_data = 32'hA7;
        #1;
        chk("t3_hazard_busy", o_hazard, 1);
        chk("t3_a_blocked", o_a_ready, 0);
        step();
        i_a_valid = 1; i_a_rd = 7; i_a_data = 32'hA7;
        i_b_valid = 1; i_b_rd = 7; i_b_data = 32'hB7;
        #1;
        chk("t3_a_blocked2", o_a_ready, 0);
        chk("t3_b_rdy", o_b_ready, 1);
        exp_wr(7, 32'hB7);
        step();
        i_a_valid = 1; i_a_rd = 7; i_a_data = 32'hA7;
        #1;
        chk("t3_busy_clr", o_busy, 0);
        chk("t3_a_rdy", o_a_ready, 1);
        chk("t3_hazard_inflight", o_hazard, 1);
        exp_wr(7, 32'hA7);
        step();
        i_dec_rs2 = 0;
        #1;
        chk("t3_hazard_x0", o_hazard, 0);
        step();

        // 4: release and re-reserve in the same cycle
        i_issue_valid = 1; i_issue_rd = 9;
        step();
        chk("t4_busy9", o_busy, 32'h0000_0200);
        i_b_valid = 1; i_b_rd = 9; i_b_data = 32'h99;
        i_issue_valid = 1; i_issue_rd = 9;
        #1;
        chk("t4_iss_refused", o_issue_ready, 0);
        chk("t4_b_rdy", o_b_ready, 1);
        exp_wr(9, 32'h99);
        step();
        chk("t4_busy9_clr", o_busy, 0);
        i_issue_valid = 1; i_issue_rd = 9;
        #1;
        chk("t4_reissue_rdy", o_issue_ready, 1);
        step();
        chk("t4_busy9_again", o_busy, 32'h0000_0200);
        i_b_valid = 1; i_b_rd = 9; i_b_data = 32'h9A;
        exp_wr(9, 32'h9A);
        step();
        i_b_valid = 1; i_b_rd = 11; i_b_data = 32'hBB;
        i_issue_valid = 1; i_issue_rd = 11;
        #1;
        chk("t4_set_clr_iss", o_issue_ready, 1);
        chk("t4_set_clr_b", o_b_ready, 1);
        exp_wr(11, 32'hBB);
        step();
        chk("t4_set_wins", o_busy, 32'h0000_0800);
        i_b_valid = 1; i_b_rd = 11; i_b_data = 32'hBC;
        exp_wr(11, 32'hBC);
        step();
        chk("t4_busy_empty", o_busy, 0);

        // 5: x0 write accepted but never enabled; x0 issue leaves no state
        i_a_valid = 1; i_a_rd = 0; i_a_data = 32'h1234;
        #1;
        chk("t5_a_rdy", o_a_ready, 1);
        step();
        chk("t5_wren", o_rd_wren, 0);
        chk("t5_data", o_rd_data, 32'h1234);
        i_issue_valid = 1; i_issue_rd = 0;
        #1;
        chk("t5_iss_rdy", o_issue_ready, 1);
        step();
        chk("t5_busy", o_busy, 0);

        // 6: async reset with a write on the port and reservations held
        i_issue_valid = 1; i_issue_rd = 2;
        step();
        i_issue_valid = 1; i_issue_rd = 7;
        step();
        chk("t6_busy", o_busy, 32'h0000_0084);
        i_dec_rd = 2;
        i_a_valid = 1; i_a_rd = 5; i_a_data = 32'h55;
        #1;
        chk("t6_hazard_rd", o_hazard, 1);
        chk("t6_a_rdy", o_a_ready, 1);
        exp_wr(5, 32'h55);
        step();
        i_dec_rd = 0;
        @(negedge i_clk);
        #1;
        chk("t6_pre_wren", o_rd_wren, 1);
        chk("t6_pre_busy", o_busy, 32'h0000_0084);
        i_rst = 1'b1;
        #1;
        chk("t6_rst_wren", o_rd_wren, 0);
        chk("t6_rst_busy", o_busy, 0);
        chk("t6_rst_addr", o_rd_addr, 0);
        step();
        i_rst = 1'b0;
        step();
        step();
        chk("sb_drain", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
